// File: rtl/nand_req_sequencer_pkg.sv
// Shared encodings for the NAND request sequencer: host ops, controller commands,
// response error codes, FSM states and the latched request payload.
package nand_req_sequencer_pkg;

    localparam int unsigned PAGE_BYTES_DEF = 4314;
    localparam int unsigned LEN_W          = 13;
    localparam int unsigned ADDR_W         = 32;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_PROG  = 2'd1,
        OP_ERASE = 2'd2,
        OP_RSVD  = 2'd3
    } req_op_e;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_READ  = 3'd1,
        CMD_PROG  = 3'd2,
        CMD_ERASE = 3'd3
    } ctrl_cmd_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_BAD     = 2'd1,
        ERR_TIMEOUT = 2'd2
    } rsp_err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WDATA,
        ST_RDATA,
        ST_WAIT_DONE,
        ST_RESP
    } seq_state_e;

    typedef struct packed {
        req_op_e           op;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } req_t;

    function automatic ctrl_cmd_e op_to_cmd(input req_op_e op);
        ctrl_cmd_e cmd;
        cmd = CMD_NONE;
        case (op)
            OP_READ:  cmd = CMD_READ;
            OP_PROG:  cmd = CMD_PROG;
            OP_ERASE: cmd = CMD_ERASE;
            default:  cmd = CMD_NONE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/nand_seq_watchdog.sv
// Per-request watchdog: cleared by load, counts while enabled, flags the last
// allowed cycle so the sequencer can abort with a timeout response.
module nand_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned TO_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire_c
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt_q;

    assign expire_c = en & (cnt_q == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (en && !expire_c) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

endmodule

// File: rtl/nand_req_sequencer.sv
// Host-side request sequencer feeding the NAND controller: validates requests,
// issues commands, streams program/read bytes and returns one response each.
module nand_req_sequencer
    import nand_req_sequencer_pkg::*;
#(
    parameter int unsigned PAGE_BYTES     = PAGE_BYTES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned TO_W           = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              rsp_valid,
    output logic [7:0]        rsp_status,
    output logic [1:0]        rsp_err,
    output logic [2:0]        CMD,
    output logic [ADDR_W-1:0] ADDR,
    output logic [LEN_W-1:0]  LEN,
    output logic              CMD_LOADED,
    output logic [7:0]        DATA_IN,
    output logic              DATA_LOADED,
    input  logic              DONE,
    input  logic              DATA_READY,
    input  logic              DATA_DONE,
    input  logic [7:0]        DATA_OUT,
    input  logic [7:0]        status
);

    seq_state_e       state_q, state_d;
    req_t             req_q;
    logic [LEN_W-1:0] cnt_q;
    rsp_err_e         err_d;
    logic [7:0]       status_d;
    logic             bad_c, last_c, wr_fire_c, rd_fire_c;
    logic             wd_load_c, wd_en_c, wd_expire_c;

    // Byte accepted at most every other cycle so the controller can drop DATA_READY.
    assign wr_ready  = (state_q == ST_WDATA) & DATA_READY & ~DATA_LOADED;
    assign wr_fire_c = wr_ready & wr_valid;
    assign rd_fire_c = (state_q == ST_RDATA) & DATA_DONE;
    assign last_c    = (cnt_q + LEN_W'(1)) == req_q.len;
    assign bad_c     = (req_q.op == OP_RSVD) ||
                       ((req_q.op != OP_ERASE) &&
                        ((req_q.len == '0) || (req_q.len > LEN_W'(PAGE_BYTES))));

    // Counting starts in the ISSUE cycle so a timeout lands TIMEOUT_CYCLES after it.
    assign wd_load_c = (state_q == ST_CHECK);
    assign wd_en_c   = (state_q == ST_ISSUE) | (state_q == ST_WDATA) |
                       (state_q == ST_RDATA) | (state_q == ST_WAIT_DONE);

    nand_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .load    (wd_load_c),
        .en      (wd_en_c),
        .expire_c(wd_expire_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        err_d    = ERR_OK;
        status_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (bad_c) begin
                    state_d = ST_RESP;
                    err_d   = ERR_BAD;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                case (req_q.op)
                    OP_PROG: state_d = ST_WDATA;
                    OP_READ: state_d = ST_RDATA;
                    default: state_d = ST_WAIT_DONE;
                endcase
            end
            ST_WDATA: begin
                if (wd_expire_c) begin
                    state_d = ST_RESP;
                    err_d   = ERR_TIMEOUT;
                end else if (wr_fire_c && last_c) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_RDATA: begin
                // An early DONE ends the read as a tolerated short transfer.
                if (DONE) begin
                    state_d  = ST_RESP;
                    status_d = status;
                end else if (wd_expire_c) begin
                    state_d = ST_RESP;
                    err_d   = ERR_TIMEOUT;
                end else if (rd_fire_c && last_c) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (DONE) begin
                    state_d  = ST_RESP;
                    status_d = status;
                end else if (wd_expire_c) begin
                    state_d = ST_RESP;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs decoded from the next state, plus request/byte datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready   <= 1'b1;
            req_q       <= '0;
            cnt_q       <= '0;
            CMD         <= CMD_NONE;
            ADDR        <= '0;
            LEN         <= '0;
            CMD_LOADED  <= 1'b0;
            DATA_IN     <= '0;
            DATA_LOADED <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_status  <= '0;
            rsp_err     <= '0;
        end else begin
            req_ready   <= (state_d == ST_IDLE);
            CMD_LOADED  <= (state_d == ST_ISSUE);
            DATA_LOADED <= wr_fire_c;
            rd_valid    <= rd_fire_c;
            rsp_valid   <= (state_d == ST_RESP);
            if (state_q == ST_IDLE && req_valid && req_ready) begin
                req_q.op   <= req_op_e'(req_op);
                req_q.addr <= req_addr;
                req_q.len  <= req_len;
            end
            if (state_d == ST_ISSUE) begin
                CMD  <= op_to_cmd(req_q.op);
                ADDR <= req_q.addr;
                LEN  <= req_q.len;
            end else if (state_d == ST_RESP) begin
                CMD <= CMD_NONE;
            end
            if (wr_fire_c) DATA_IN <= wr_data;
            if (rd_fire_c) rd_data <= DATA_OUT;
            if (state_d == ST_RESP) begin
                rsp_status <= status_d;
                rsp_err    <= err_d;
            end
            if (state_q == ST_ISSUE) begin
                cnt_q <= '0;
            end else if (wr_fire_c || rd_fire_c) begin
                cnt_q <= cnt_q + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nand_req_sequencer.sv
// Directed bench for nand_req_sequencer; dut_a uses the default watchdog,
// dut_b shares all stimulus but times out after 50 cycles.
module tb_nand_req_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [12:0] req_len;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        done;
    logic        data_ready;
    logic        data_done;
    logic [7:0]  data_out;
    logic [7:0]  status;

    logic        a_req_ready, a_wr_ready, a_rd_valid, a_rsp_valid, a_cmd_loaded, a_data_loaded;
    logic [7:0]  a_rd_data, a_rsp_status, a_data_in;
    logic [1:0]  a_rsp_err;
    logic [2:0]  a_cmd;
    logic [31:0] a_addr;
    logic [12:0] a_len;
    logic        b_req_ready, b_wr_ready, b_rd_valid, b_rsp_valid, b_cmd_loaded, b_data_loaded;
    logic [7:0]  b_rd_data, b_rsp_status, b_data_in;
    logic [1:0]  b_rsp_err;
    logic [2:0]  b_cmd;
    logic [31:0] b_addr;
    logic [12:0] b_len;

    int n_cmp = 0;
    int n_fail = 0;
    int n_cmdld_a = 0;
    int n_rsp_a = 0;

    always #5 clk = ~clk;

    nand_req_sequencer dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(a_wr_ready),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rsp_valid(a_rsp_valid),
        .rsp_status(a_rsp_status), .rsp_err(a_rsp_err), .CMD(a_cmd), .ADDR(a_addr),
        .LEN(a_len), .CMD_LOADED(a_cmd_loaded), .DATA_IN(a_data_in),
        .DATA_LOADED(a_data_loaded), .DONE(done), .DATA_READY(data_ready),
        .DATA_DONE(data_done), .DATA_OUT(data_out), .status(status)
    );

    nand_req_sequencer #(.TIMEOUT_CYCLES(50), .TO_W(20)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(b_wr_ready),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rsp_valid(b_rsp_valid),
        .rsp_status(b_rsp_status), .rsp_err(b_rsp_err), .CMD(b_cmd), .ADDR(b_addr),
        .LEN(b_len), .CMD_LOADED(b_cmd_loaded), .DATA_IN(b_data_in),
        .DATA_LOADED(b_data_loaded), .DONE(done), .DATA_READY(data_ready),
        .DATA_DONE(data_done), .DATA_OUT(data_out), .status(status)
    );

    always @(posedge clk) begin
        if (a_cmd_loaded) n_cmdld_a++;
        if (a_rsp_valid)  n_rsp_a++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [1:0] op, input logic [31:0] addr, input logic [12:0] len);
        chk("req_ready", 32'(a_req_ready), 1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_len   = len;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_cmd_a();
        for (int i = 0; i < 8 && !a_cmd_loaded; i++) tick();
        chk("cmd_loaded", 32'(a_cmd_loaded), 1);
    endtask

    task automatic pulse_done(input logic [7:0] st);
        done   = 1'b1;
        status = st;
        tick();
        done   = 1'b0;
        status = 8'h00;
    endtask

    // Offers program bytes A1.. until `stop` DATA_LOADED pulses have been observed.
    task automatic feed_prog(input int stop);
        logic [7:0] pb [4];
        int k_in, k_out, last, cyc;
        pb[0] = 8'hA1; pb[1] = 8'hA2; pb[2] = 8'hA3; pb[3] = 8'hA4;
        k_in = 0; k_out = 0; last = 0; cyc = 0;
        while (k_out < stop && cyc < 40) begin
            if (a_data_loaded) begin
                chk("prog_data_in", 32'(a_data_in), 32'(pb[k_out]));
                if (k_out > 0) chk("prog_gap", 32'(cyc - last), 2);
                last = cyc;
                k_out++;
            end
            if (k_in < 4) begin
                wr_valid = 1'b1;
                wr_data  = pb[k_in];
            end else begin
                wr_valid = 1'b0;
            end
            #1;
            if (wr_valid && a_wr_ready) k_in++;
            tick();
            cyc++;
        end
        wr_valid = 1'b0;
        chk("prog_bytes_seen", 32'(k_out), 32'(stop));
    endtask

    initial begin
        int c0, r0, cyc, found;
        logic [7:0]  rb [3];
        logic [1:0]  bop [3];
        logic [12:0] blen [3];

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_len = '0;
        wr_data = '0; wr_valid = 1'b0; done = 1'b0; data_ready = 1'b0;
        data_done = 1'b0; data_out = '0; status = '0;
        repeat (2) tick();
        chk("rst_req_ready", 32'(a_req_ready), 1);
        chk("rst_cmd", 32'(a_cmd), 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_cmd_loaded", 32'(a_cmd_loaded), 0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 0);
        reset = 1'b0;
        tick();

        // Erase completing 100 cycles after the command
        c0 = n_cmdld_a; r0 = n_rsp_a;
        send_req(2'd2, 32'h0004_0000, 13'd0);
        wait_cmd_a();
        chk("erase_cmd", 32'(a_cmd), 3);
        chk("erase_addr", a_addr, 32'h0004_0000);
        repeat (100) tick();
        chk("erase_no_early_rsp", 32'(n_rsp_a - r0), 0);
        pulse_done(8'hE0);
        chk("erase_rsp_valid", 32'(a_rsp_valid), 1);
        chk("erase_rsp_status", 32'(a_rsp_status), 32'hE0);
        chk("erase_rsp_err", 32'(a_rsp_err), 0);
        chk("erase_cmd_cleared", 32'(a_cmd), 0);
        chk("erase_one_cmd_loaded", 32'(n_cmdld_a - c0), 1);
        tick();

        // Program of four bytes with DATA_READY held high
        data_ready = 1'b1;
        send_req(2'd1, 32'h0000_1000, 13'd4);
        wait_cmd_a();
        chk("prog_cmd", 32'(a_cmd), 2);
        chk("prog_len", 32'(a_len), 4);
        feed_prog(4);
        repeat (2) tick();
        pulse_done(8'h5A);
        chk("prog_rsp_valid", 32'(a_rsp_valid), 1);
        chk("prog_rsp_status", 32'(a_rsp_status), 32'h5A);
        chk("prog_rsp_err", 32'(a_rsp_err), 0);
        data_ready = 1'b0;
        tick();

        // Read of three bytes
        rb[0] = 8'h11; rb[1] = 8'h22; rb[2] = 8'h33;
        send_req(2'd0, 32'h0000_2000, 13'd3);
        wait_cmd_a();
        chk("read_cmd", 32'(a_cmd), 1);
        chk("read_len", 32'(a_len), 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            data_done = 1'b1;
            data_out  = rb[i];
            tick();
            data_done = 1'b0;
            data_out  = 8'h00;
            chk("read_rd_valid", 32'(a_rd_valid), 1);
            chk("read_rd_data", 32'(a_rd_data), 32'(rb[i]));
            tick();
            chk("read_rd_valid_low", 32'(a_rd_valid), 0);
        end
        pulse_done(8'hC0);
        chk("read_rsp_valid", 32'(a_rsp_valid), 1);
        chk("read_rsp_status", 32'(a_rsp_status), 32'hC0);
        chk("read_rsp_err", 32'(a_rsp_err), 0);
        tick();

        // Maximum legal length, ended early by DONE (short read)
        send_req(2'd0, 32'h0000_3000, 13'd4314);
        wait_cmd_a();
        chk("maxlen_len", 32'(a_len), 4314);
        tick();
        data_done = 1'b1;
        data_out  = 8'h5C;
        tick();
        data_done = 1'b0;
        chk("short_rd_data", 32'(a_rd_data), 32'h5C);
        pulse_done(8'h81);
        chk("short_rsp_valid", 32'(a_rsp_valid), 1);
        chk("short_rsp_status", 32'(a_rsp_status), 32'h81);
        chk("short_rsp_err", 32'(a_rsp_err), 0);
        tick();

        // Rejected requests: reserved op, zero-length read, oversize program
        bop[0] = 2'd3; blen[0] = 13'd5;
        bop[1] = 2'd0; blen[1] = 13'd0;
        bop[2] = 2'd1; blen[2] = 13'd4315;
        for (int i = 0; i < 3; i++) begin
            c0 = n_cmdld_a;
            send_req(bop[i], 32'h0000_0100, blen[i]);
            found = 0;
            for (int j = 0; j < 3 && found == 0; j++) begin
                if (a_rsp_valid) found = 1;
                else tick();
            end
            chk("bad_rsp_seen", 32'(found), 1);
            chk("bad_rsp_err", 32'(a_rsp_err), 1);
            chk("bad_cmd", 32'(a_cmd), 0);
            repeat (2) tick();
            chk("bad_no_cmd_loaded", 32'(n_cmdld_a - c0), 0);
        end

        // Watchdog expiry on dut_b, late DONE ignored there
        send_req(2'd2, 32'h0008_0000, 13'd0);
        wait_cmd_a();
        chk("to_b_cmd_loaded", 32'(b_cmd_loaded), 1);
        cyc = 0;
        while (!b_rsp_valid && cyc < 80) begin
            tick();
            cyc++;
        end
        chk("to_latency", 32'(cyc), 50);
        chk("to_rsp_err", 32'(b_rsp_err), 2);
        chk("to_rsp_status", 32'(b_rsp_status), 0);
        chk("to_cmd_cleared", 32'(b_cmd), 0);
        chk("to_a_still_busy", 32'(a_rsp_valid), 0);
        repeat (6) tick();
        pulse_done(8'h33);
        chk("late_a_rsp_valid", 32'(a_rsp_valid), 1);
        chk("late_a_rsp_status", 32'(a_rsp_status), 32'h33);
        chk("late_b_ignored", 32'(b_rsp_valid), 0);
        tick();
        chk("next_b_req_ready", 32'(b_req_ready), 1);
        send_req(2'd2, 32'h000C_0000, 13'd0);
        wait_cmd_a();
        chk("next_b_cmd_loaded", 32'(b_cmd_loaded), 1);
        repeat (3) tick();
        pulse_done(8'h44);
        chk("next_b_rsp_valid", 32'(b_rsp_valid), 1);
        chk("next_b_rsp_status", 32'(b_rsp_status), 32'h44);
        chk("next_b_rsp_err", 32'(b_rsp_err), 0);
        tick();

        // Reset in the middle of a program after two bytes
        data_ready = 1'b1;
        send_req(2'd1, 32'h0000_5000, 13'd4);
        wait_cmd_a();
        feed_prog(2);
        r0 = n_rsp_a;
        reset = 1'b1;
        data_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_req_ready", 32'(a_req_ready), 1);
        chk("mid_rst_cmd", 32'(a_cmd), 0);
        chk("mid_rst_addr", a_addr, 0);
        chk("mid_rst_len", 32'(a_len), 0);
        chk("mid_rst_data_in", 32'(a_data_in), 0);
        chk("mid_rst_data_loaded", 32'(a_data_loaded), 0);
        chk("mid_rst_wr_ready", 32'(a_wr_ready), 0);
        chk("mid_rst_no_rsp", 32'(n_rsp_a - r0), 0);
        send_req(2'd0, 32'h0000_6000, 13'd1);
        wait_cmd_a();
        tick();
        data_done = 1'b1;
        data_out  = 8'h77;
        tick();
        data_done = 1'b0;
        chk("post_rst_rd_data", 32'(a_rd_data), 32'h77);
        pulse_done(8'hC1);
        chk("post_rst_rsp_valid", 32'(a_rsp_valid), 1);
        chk("post_rst_rsp_status", 32'(a_rsp_status), 32'hC1);
        chk("post_rst_rsp_err", 32'(a_rsp_err), 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
